btb_update_arbiter: RTL

Shares the single-ported BTB/LHT prediction arrays between front-end fetch lookups and predictor updates from the branch functional unit. Branch results are buffered in a small FIFO and written back when fetch is idle. A starvation counter or a full queue forces a write by stalling fetch for one cycle. Queued targets are forwarded to fetch so a lookup never misses an update that is still waiting in the queue.

---
 rtl/btb_update_arbiter_if.sv | 34 +++
 rtl/btb_update_arbiter.sv | 112 +++++++++++
 2 files changed

// File: rtl/btb_update_arbiter_if.sv
// Signal bundle between the branch unit / fetch front-end and the BTB/LHT update arbiter.
// Update handshake: an update transfers on every rising edge where upd_valid && upd_ready && !flush.
// upd_ready depends only on registered occupancy, never on upd_valid.
interface btb_update_arbiter_if #(
  parameter int IDX_BITS = 8
);
  logic                upd_valid;
  logic                upd_ready;
  logic                upd_btb_en;
  logic [IDX_BITS-1:0] upd_addr;
  logic [31:0]         upd_target;
  logic [7:0]          upd_lht;
  logic                flush;
  logic                fetch_req;
  logic [IDX_BITS-1:0] fetch_addr;
  logic                fetch_stall;
  logic                fwd_valid;
  logic [31:0]         fwd_target;
  logic [IDX_BITS-1:0] arr_addr;
  logic                btb_web;
  logic                lht_web;
  logic [31:0]         btb_din;
  logic [7:0]          lht_din;

  modport master (
    output upd_valid, upd_btb_en, upd_addr, upd_target, upd_lht, flush, fetch_req, fetch_addr,
    input  upd_ready, fetch_stall, fwd_valid, fwd_target, arr_addr, btb_web, lht_web, btb_din, lht_din
  );

  modport slave (
    input  upd_valid, upd_btb_en, upd_addr, upd_target, upd_lht, flush, fetch_req, fetch_addr,
    output upd_ready, fetch_stall, fwd_valid, fwd_target, arr_addr, btb_web, lht_web, btb_din, lht_din
  );
endinterface

// File: rtl/btb_update_arbiter.sv
// Arbitrates the single BTB/LHT array port between fetch lookups and queued branch-unit updates,
// forwarding queued targets so fetch never reads a stale BTB entry.
module btb_update_arbiter #(
  parameter int DEPTH        = 4,
  parameter int IDX_BITS     = 8,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  btb_update_arbiter_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ST_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(DEPTH);
  localparam logic [ST_W-1:0]  STARVE_MAX = ST_W'(STARVE_LIMIT - 1);

  typedef struct packed {
    logic                btb_en;
    logic [IDX_BITS-1:0] addr;
    logic [31:0]         target;
    logic [7:0]          lht;
  } entry_t;

  entry_t            q [DEPTH];
  entry_t            head_e;
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;
  logic [ST_W-1:0]   starve_cnt;
  logic              empty;
  logic              full;
  logic              push;
  logic              drain;

  assign empty  = (count == '0);
  assign full   = (count == FULL_CNT);
  assign push   = bus.upd_valid && !full && !bus.flush;
  assign drain  = !empty && !bus.flush &&
                  (!bus.fetch_req || (starve_cnt == STARVE_MAX) || full);
  assign head_e = q[head];

  // Array port: a drain owns it, otherwise fetch does. Reset forces the idle values.
  always_comb begin
    bus.upd_ready   = !full;
    bus.fetch_stall = drain && bus.fetch_req;
    bus.arr_addr    = bus.fetch_addr;
    bus.btb_web     = 1'b1;
    bus.lht_web     = 1'b1;
    bus.btb_din     = '0;
    bus.lht_din     = '0;
    if (rst) begin
      bus.arr_addr = '0;
    end else if (drain) begin
      bus.arr_addr = head_e.addr;
      bus.btb_web  = !head_e.btb_en;
      bus.lht_web  = 1'b0;
      bus.btb_din  = head_e.target;
      bus.lht_din  = head_e.lht;
    end
  end

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx            = '0;
    bus.fwd_valid  = 1'b0;
    bus.fwd_target = '0;
    if (!bus.flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        idx = head + PTR_W'(i);
        if ((CNT_W'(i) < count) && q[idx].btb_en && (q[idx].addr == bus.fetch_addr)) begin
          bus.fwd_valid  = 1'b1;
          bus.fwd_target = q[idx].target;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q[tail] <= '{btb_en: bus.upd_btb_en, addr: bus.upd_addr,
                   target: bus.upd_target, lht: bus.upd_lht};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      starve_cnt <= '0;
    end else if (bus.flush) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      starve_cnt <= '0;
    end else begin
      if (push)  tail <= tail + PTR_W'(1);
      if (drain) head <= head + PTR_W'(1);
      unique case ({push, drain})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (drain || empty)
        starve_cnt <= '0;
      else if (starve_cnt != STARVE_MAX)
        starve_cnt <= starve_cnt + ST_W'(1);
    end
  end
endmodule
